// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Purpose: the register file has one write port, and two sources need it. This
// block shares that port between the in-order writeback stage (WB) and a
// long-latency result source (LU). LU results wait in a small FIFO until WB
// leaves the port free. A pending-destination scoreboard lets decode stall on
// hazards against LU writes that are still outstanding. A starvation counter
// asks upstream for one WB bubble when LU results have been waiting too long.
//
// Ports:
//   clk, rst                     clock (rising edge), synchronous active-high reset
//   wb_valid/wb_addr/wb_data     writeback request; always wins the port
//   lu_valid/lu_addr/lu_data     long-latency result, accepted when lu_ready
//   lu_ready                     FIFO not full (registered state only)
//   issue_valid/issue_addr       decode issues an LU op; marks its destination pending
//   chk_rs/chk_rt/chk_rd         decode operands to test against the scoreboard
//   stall                        some decode operand has an outstanding LU write
//   pipe_hold                    one-cycle request for a WB bubble
//   write_enabled/addr/data      registered write port of the register file
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
   parameter int DEPTH        = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wb_valid,
   input  logic [4:0]  wb_addr,
   input  logic [31:0] wb_data,
   input  logic        lu_valid,
   output logic        lu_ready,
   input  logic [4:0]  lu_addr,
   input  logic [31:0] lu_data,
   input  logic        issue_valid,
   input  logic [4:0]  issue_addr,
   input  logic [4:0]  chk_rs,
   input  logic [4:0]  chk_rt,
   input  logic [4:0]  chk_rd,
   output logic        stall,
   output logic        pipe_hold,
   output logic        write_enabled,
   output logic [4:0]  write_addr,
   output logic [31:0] write_data
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam int STV_W = $clog2(STARVE_LIMIT + 1);

   logic [4:0]       fifo_addr [DEPTH];
   logic [31:0]      fifo_data [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;
   logic [4:0]       head_addr;
   logic [31:0]      head_data;

   logic             win_p0;
   logic             vld_p0;
   logic [4:0]       addr_p0;
   logic [31:0]      data_p0;

   logic [31:0]      pending;
   logic [31:0]      pending_nxt;
   logic [STV_W-1:0] starve_cnt;

   assign full      = (count == CNT_W'(DEPTH));
   assign empty     = (count == '0);
   assign lu_ready  = ~full;
   assign push      = lu_valid & ~full;
   // The head can leave only when WB does not claim the port. The head always
   // comes from registered FIFO state, so a result pushed this cycle waits
   // until the next cycle at the earliest.
   assign pop       = ~wb_valid & ~empty;
   assign head_addr = fifo_addr[rd_ptr];
   assign head_data = fifo_data[rd_ptr];

   // FIFO storage holds data only, so it needs no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr[wr_ptr] <= lu_addr;
         fifo_data[wr_ptr] <= lu_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // ---- stage p0: pick the port winner for this cycle ----
   always_comb begin
      win_p0  = 1'b0;
      addr_p0 = '0;
      data_p0 = '0;
      if (wb_valid) begin
         win_p0  = 1'b1;
         addr_p0 = wb_addr;
         data_p0 = wb_data;
      end else if (!empty) begin
         win_p0  = 1'b1;
         addr_p0 = head_addr;
         data_p0 = head_data;
      end
   end

   // A winner with destination r0 still uses its slot, but no write is issued.
   assign vld_p0 = win_p0 & (addr_p0 != 5'd0);

   // ---- stage p1: registered write port ----
   always_ff @(posedge clk) begin
      if (rst) begin
         write_enabled <= 1'b0;
         write_addr    <= '0;
         write_data    <= '0;
      end else begin
         write_enabled <= vld_p0;
         if (win_p0) begin
            write_addr <= addr_p0;
            write_data <= data_p0;
         end
      end
   end

   // Scoreboard. The clear is applied before the set, so an issue to an
   // address wins over a pop to the same address in the same cycle.
   always_comb begin
      pending_nxt = pending;
      if (pop) begin
         pending_nxt[head_addr] = 1'b0;
      end
      if (issue_valid) begin
         pending_nxt[issue_addr] = 1'b1;
      end
      pending_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pending <= '0;
      end else begin
         pending <= pending_nxt;
      end
   end

   assign stall = pending[chk_rs] | pending[chk_rt] | pending[chk_rd];

   // Starvation counter. When the FIFO is non-empty and nothing pops, WB must
   // be holding the port. The counter restarts from zero after each pipe_hold
   // pulse, so it does not re-arm before STARVE_LIMIT more such cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt <= '0;
         pipe_hold  <= 1'b0;
      end else if (empty || pop) begin
         starve_cnt <= '0;
         pipe_hold  <= 1'b0;
      end else if (starve_cnt == STV_W'(STARVE_LIMIT - 1)) begin
         starve_cnt <= '0;
         pipe_hold  <= 1'b1;
      end else begin
         starve_cnt <= starve_cnt + STV_W'(1);
         pipe_hold  <= 1'b0;
      end
   end

endmodule
